// File: rtl/config_sequencer_if.sv
// config_sequencer_if: host-to-sequencer word handshake (valid/ready plus tile/addr/data/last/parity).
interface config_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_tile_id;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_parity;
    modport master (
        output in_valid, in_tile_id, in_addr, in_data, in_last, in_parity,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_tile_id, in_addr, in_data, in_last, in_parity,
        output in_ready
    );
endinterface

// File: rtl/config_sequencer.sv
// config_sequencer: buffers host config words in a 4-entry FIFO and issues them to tiles one per cycle.
// Optional CFG_SEQ_PARITY_EN: drop and flag words failing even parity over {tile,addr,data,parity}.
module config_sequencer (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    config_sequencer_if.slave   host,
    output logic                cfg_en,
    output logic [15:0]         tile_id,
    output logic [31:0]         config_addr,
    output logic [31:0]         config_data,
    output logic                busy,
    output logic                done,
    output logic [15:0]         word_count,
    output logic                err
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
    state_t      state;
    logic [79:0] fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        accept, push, pop, bad;
`ifdef CFG_SEQ_PARITY_EN
    assign bad = ^{host.in_tile_id, host.in_addr, host.in_data, host.in_parity};
`else
    logic unused_parity;
    assign unused_parity = host.in_parity;
    assign bad = 1'b0;
`endif
    assign host.in_ready = state == LOAD && count != 3'd4;
    assign accept = host.in_valid && host.in_ready;
    assign push = accept && !bad;
    assign pop = (state == LOAD || state == FLUSH) && count != 3'd0;
    assign busy = state == LOAD || state == FLUSH;
    always_ff @(posedge clk)
        if (push) fifo_mem[wr_ptr] <= {host.in_tile_id, host.in_addr, host.in_data};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            count       <= 3'd0;
            cfg_en      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            word_count  <= 16'd0;
            tile_id     <= 16'd0;
            config_addr <= 32'd0;
            config_data <= 32'd0;
        end else begin
            cfg_en <= pop;
            done   <= 1'b0;
            count  <= count + {2'd0, push} - {2'd0, pop};
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop) begin
                {tile_id, config_addr, config_data} <= fifo_mem[rd_ptr];
                rd_ptr     <= rd_ptr + 2'd1;
                word_count <= word_count == 16'hFFFF ? word_count : word_count + 16'd1;
            end
            if (accept && bad) err <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    state      <= LOAD;
                    word_count <= 16'd0;
                    err        <= 1'b0;
                end
                LOAD: if (accept && host.in_last) state <= FLUSH;
                FLUSH: if (count == 3'd0) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
